si_dac: RTL and testbench



---
 rtl/si_dac_pkg.sv | 15 +
 rtl/si_dac_if.sv | 23 ++
 rtl/si_shift_reg.sv | 48 ++++
 rtl/si_dac.sv | 46 ++++
 tb/tb_si_dac.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/si_dac_pkg.sv
// Shared defaults and the code-to-voltage conversion for the serial-input DAC.
package si_dac_pkg;

  localparam int  DEF_WIDTH = 12;
  localparam int  MAX_WIDTH = 16;
  localparam real DEF_VREF  = 1.0;

  typedef logic [MAX_WIDTH-1:0] code_t;

  // Full scale is 2**width, so the top code lands one LSB below vref.
  function automatic real code2volt(input code_t code, input int width, input real vref);
    return vref * real'(code) / real'(64'd1 << width);
  endfunction

endpackage

// File: rtl/si_dac_if.sv
// Serial input frame and DAC output bundle; the source drives master, the DAC is slave.
interface si_dac_if import si_dac_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             SI;
  logic             SI_en;
  logic             soc;
  real              A_out;
  logic [WIDTH-1:0] D_out;
  logic             eoc;

  modport master (
    output SI, SI_en, soc,
    input  A_out, D_out, eoc
  );

  modport slave (
    input  SI, SI_en, soc,
    output A_out, D_out, eoc
  );

endinterface

// File: rtl/si_shift_reg.sv
// MSB-first shift register with bit counter; flags the cycle whose edge samples the last bit.
module si_shift_reg import si_dac_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_si,
  input  logic             i_si_en,
  input  logic             i_soc,
  output logic [WIDTH-1:0] o_word,
  output logic             o_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Only WIDTH-1 bits need storing: the final bit goes straight to the output latch.
  logic [WIDTH-2:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             w_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_next;

  assign w_bit  = (i_si === 1'b1);
  assign w_next = {r_shift, w_bit};
  assign w_last = (r_bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (!i_soc) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_si_en) begin
      if (w_last) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_shift   <= w_next[WIDTH-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign o_word = w_next;
  assign o_done = i_soc & i_si_en & w_last;

endmodule

// File: rtl/si_dac.sv
// Behavioural serial-input DAC: latches each completed word and drives the code and its voltage.
module si_dac import si_dac_pkg::*; #(
  parameter int  WIDTH = DEF_WIDTH,
  parameter real VREF  = DEF_VREF
) (
  input  logic  clk,
  input  logic  rst_n,
  si_dac_if.slave bus
);

  logic [WIDTH-1:0] w_word;
  logic             w_done;
  logic [WIDTH-1:0] r_d_out;
  logic             r_eoc;
  real              r_a_out;

  si_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_si    (bus.SI),
    .i_si_en (bus.SI_en),
    .i_soc   (bus.soc),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  // Code and voltage update on the same edge that samples the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_out <= '0;
      r_eoc   <= 1'b0;
      r_a_out <= 0.0;
    end else begin
      r_eoc <= w_done;
      if (w_done) begin
        r_d_out <= w_word;
        r_a_out <= code2volt(code_t'(w_word), WIDTH, VREF);
      end
    end
  end

  assign bus.D_out = r_d_out;
  assign bus.eoc   = r_eoc;
  assign bus.A_out = r_a_out;

endmodule

// File: tb/tb_si_dac.sv
// Scoreboard bench for si_dac: a bit-level model queues each completed code, popped on eoc.
module tb_si_dac;
  import si_dac_pkg::*;

  logic clk;
  logic rst_n;

  si_dac_if #(.WIDTH(12)) bus ();

  si_dac #(.WIDTH(12), .VREF(1.0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int q_exp[$];
  int m_cnt;
  int m_sh;
  int m_last;
  int cyc;
  int last_eoc_cyc;
  int prev_eoc_cyc;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint volt_fix(input real v);
    return longint'($rtoi(v * 1.0e9 + 0.5));
  endfunction

  function automatic longint exp_volt(input int code);
    return longint'($rtoi(real'(code) * 1.0e9 / 4096.0 + 0.5));
  endfunction

  task automatic step(input bit s, input bit e, input bit c);
    bit exp_eoc;
    int code;
    bus.SI    = s;
    bus.SI_en = e;
    bus.soc   = c;
    exp_eoc   = 1'b0;
    if (!c) begin
      m_cnt = 0;
      m_sh  = 0;
    end else if (e) begin
      m_sh = (m_sh << 1) | int'(s);
      m_cnt++;
      if (m_cnt == 12) begin
        q_exp.push_back(m_sh);
        exp_eoc = 1'b1;
        m_cnt   = 0;
        m_sh    = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("eoc", longint'(bus.eoc), longint'(exp_eoc));
    if (bus.eoc) begin
      prev_eoc_cyc = last_eoc_cyc;
      last_eoc_cyc = cyc;
      if (q_exp.size() == 0) begin
        chk("sb_empty_on_eoc", longint'(q_exp.size()), 1);
      end else begin
        code   = q_exp.pop_front();
        m_last = code;
        chk("d_out", longint'(bus.D_out), longint'(code));
        chk("a_out", volt_fix(bus.A_out), exp_volt(code));
      end
    end else begin
      chk("d_hold", longint'(bus.D_out), longint'(m_last));
    end
  endtask

  task automatic send_word(input int w);
    for (int i = 11; i >= 0; i--) step(bit'((w >> i) & 1), 1'b1, 1'b1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_cnt = 0; m_sh = 0; m_last = 0;
    cyc = 0; last_eoc_cyc = 0; prev_eoc_cyc = 0;
    rst_n     = 1'b0;
    bus.SI    = 1'b0;
    bus.SI_en = 1'b0;
    bus.soc   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_out", longint'(bus.D_out), 0);
    chk("rst_eoc",   longint'(bus.eoc), 0);
    chk("rst_a_out", volt_fix(bus.A_out), 0);
    rst_n = 1'b1;

    // half scale, eoc exactly one cycle
    send_word(12'h800);
    chk("w800_d", longint'(bus.D_out), 12'h800);
    chk("w800_a", volt_fix(bus.A_out), 500000000);
    step(1'b0, 1'b0, 1'b1);

    // back-to-back extremes
    send_word(12'hFFF);
    chk("wfff_uv", longint'($rtoi(bus.A_out * 1.0e6 + 0.5)), 999756);
    send_word(12'h001);
    chk("w001_uv", longint'($rtoi(bus.A_out * 1.0e6 + 0.5)), 244);
    chk("eoc_period", longint'(last_eoc_cyc - prev_eoc_cyc), 12);

    // SI_en gap after six bits
    for (int i = 11; i >= 6; i--) step(bit'((12'hA5A >> i) & 1), 1'b1, 1'b1);
    repeat (5) step(bit'($urandom_range(0, 1)), 1'b0, 1'b1);
    for (int i = 5; i >= 0; i--) step(bit'((12'hA5A >> i) & 1), 1'b1, 1'b1);
    chk("gap_d", longint'(bus.D_out), 12'hA5A);

    // frame abort after seven bits; soc low beats SI_en high
    for (int i = 11; i >= 5; i--) step(bit'((12'h3C3 >> i) & 1), 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("abort_hold", longint'(bus.D_out), 12'hA5A);
    send_word(12'h123);
    chk("after_abort_d", longint'(bus.D_out), 12'h123);

    // random traffic, soc toggling every 1000 cycles (10 us)
    for (int i = 0; i < 5000; i++)
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ((i / 1000) % 2) == 0);
    chk("no_x_d", longint'($isunknown(bus.D_out)), 0);
    chk("no_x_eoc", longint'($isunknown(bus.eoc)), 0);

    // async reset mid-word
    send_word(12'h7FF);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_d", longint'(bus.D_out), 0);
    chk("async_rst_eoc", longint'(bus.eoc), 0);
    chk("async_rst_a", volt_fix(bus.A_out), 0);
    m_cnt = 0; m_sh = 0; m_last = 0;
    q_exp.delete();
    #2 rst_n = 1'b1;
    send_word(12'h456);
    chk("post_rst_d", longint'(bus.D_out), 12'h456);

    chk("sb_drained", longint'(q_exp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
